record_timer: RTL and testbench

- Parametrised successor to the recorder's fixed 125000-count confirm timer.
- Counts qualifying ticks (sample strobes, or the codec-done strobe) against a limit that is latched at start.
- Supports start, pause, clear, one-shot and auto-reload operation; reports elapsed count, run state, a sticky expired flag and a one-cycle expiry pulse.
- Sits between the record/playback FSM and the audio capture path to bound recording length.

---
 rtl/record_timer.sv | 171 +++++++++++++++++
 tb/tb_record_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/record_timer.sv
// record_timer: counts qualifying ticks against a limit latched at start, with one-shot or
// auto-reload operation. Define RECORD_TIMER_WARN_EN to build the near-limit warn output.
module record_timer #(
  parameter int unsigned WIDTH         = 18,
  parameter int unsigned DEFAULT_LIMIT = 125000,
  parameter bit          USE_DEFAULT   = 1'b1,
  parameter int unsigned WARN_MARGIN   = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             tick,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] cfg_limit,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             expired_pulse,
  output logic             warn
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEF_LIM = WIDTH'(DEFAULT_LIMIT);

  if ((64'(DEFAULT_LIMIT) >= (64'd1 << WIDTH)) || (64'(WARN_MARGIN) >= (64'd1 << WIDTH))) begin : g_cfg_check
    $error("record_timer: DEFAULT_LIMIT and WARN_MARGIN must fit in WIDTH bits");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;
  logic             expire_s;
  logic [WIDTH-1:0] eff_limit_s;
  logic [WIDTH-1:0] count_inc_s;

  assign eff_limit_s = (USE_DEFAULT && (cfg_limit == ZERO)) ? DEF_LIM : cfg_limit;
  // count_q < limit_q always holds in RUN, so the increment cannot wrap
  assign count_inc_s = count_q + ONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= ZERO;
      limit_q   <= ZERO;
      reload_q  <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    expire_s = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = ZERO;
    end else if (start) begin
      limit_d  = eff_limit_s;
      reload_d = auto_reload;
      count_d  = ZERO;
      if (eff_limit_s == ZERO) begin
        state_d  = S_DONE;
        expire_s = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            if (count_inc_s == limit_q) begin
              expire_s = 1'b1;
              if (reload_q) begin
                count_d = ZERO;
              end else begin
                count_d = limit_q;
                state_d = S_DONE;
              end
            end else begin
              count_d = count_inc_s;
            end
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    pulse_d   = expire_s;
    if (clear) begin
      expired_d = 1'b0;
    end else if (start) begin
      expired_d = expire_s;
    end else begin
      expired_d = expired_q | expire_s;
    end
  end

`ifdef RECORD_TIMER_WARN_EN
  localparam logic [WIDTH-1:0] WARN_M = WIDTH'(WARN_MARGIN);
  logic warn_q, warn_d;

  // warn is derived from next-state values so it moves on the same edge as count
  always_comb begin
    if (running_d) begin
      warn_d = ((limit_d - count_d) <= WARN_M);
    end else begin
      warn_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign count         = count_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_record_timer.sv
// Bench for record_timer: directed scenarios plus random stimulus against a behavioural model,
// run on two instances (default-limit substitution on and off).
module tb_record_timer;

  localparam int W    = 8;
  localparam int DEF  = 20;
  localparam int MARG = 2;
`ifdef RECORD_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clock = 1'b0;
  logic         reset, start, pause, clear, tick, auto_reload;
  logic [W-1:0] cfg_limit;
  logic [W-1:0] count_a, count_b;
  logic         running_a, expired_a, pulse_a, warn_a;
  logic         running_b, expired_b, pulse_b, warn_b;

  record_timer #(.WIDTH(W), .DEFAULT_LIMIT(DEF), .USE_DEFAULT(1'b1), .WARN_MARGIN(MARG)) dut_a (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear), .tick(tick),
    .auto_reload(auto_reload), .cfg_limit(cfg_limit), .count(count_a), .running(running_a),
    .expired(expired_a), .expired_pulse(pulse_a), .warn(warn_a));

  record_timer #(.WIDTH(W), .DEFAULT_LIMIT(DEF), .USE_DEFAULT(1'b0), .WARN_MARGIN(MARG)) dut_b (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear), .tick(tick),
    .auto_reload(auto_reload), .cfg_limit(cfg_limit), .count(count_b), .running(running_b),
    .expired(expired_b), .expired_pulse(pulse_b), .warn(warn_b));

  always #5 clock = ~clock;

  typedef struct {
    int mode;
    int count;
    int limit;
    bit reload;
    bit expired;
    bit pulse;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic mdl_t model_reset();
    mdl_t m;
    m.mode = M_IDLE; m.count = 0; m.limit = 0; m.reload = 1'b0; m.expired = 1'b0; m.pulse = 1'b0;
    return m;
  endfunction

  // one clock of the timer rules, evaluated in priority order clear > start > pause > tick
  function automatic mdl_t model_step(mdl_t m, bit use_def, bit st, bit ps, bit cl, bit tk, bit ar, int cfg);
    mdl_t n = m;
    int   lim;
    n.pulse = 1'b0;
    if (cl) begin
      n.mode = M_IDLE; n.count = 0; n.expired = 1'b0;
    end else if (st) begin
      lim = (use_def && cfg == 0) ? DEF : cfg;
      n.limit = lim; n.reload = ar; n.count = 0;
      if (lim == 0) begin
        n.mode = M_DONE; n.expired = 1'b1; n.pulse = 1'b1;
      end else begin
        n.mode = M_RUN; n.expired = 1'b0;
      end
    end else if (m.mode == M_RUN) begin
      if (ps) n.mode = M_PAUSE;
      else if (tk) begin
        if (m.count + 1 == m.limit) begin
          n.expired = 1'b1; n.pulse = 1'b1;
          if (m.reload) n.count = 0;
          else begin n.count = m.limit; n.mode = M_DONE; end
        end else n.count = m.count + 1;
      end
    end else if (m.mode == M_PAUSE && !ps) begin
      n.mode = M_RUN;
    end
    return n;
  endfunction

  task automatic compare_one(input string id, input mdl_t m, input logic [W-1:0] c, input logic r,
                             input logic e, input logic p, input logic w);
    bit run_exp;
    run_exp = (m.mode == M_RUN) || (m.mode == M_PAUSE);
    check({id, ".count"}, 32'(c), 32'(m.count));
    check({id, ".running"}, 32'(r), 32'(run_exp));
    check({id, ".expired"}, 32'(e), 32'(m.expired));
    check({id, ".pulse"}, 32'(p), 32'(m.pulse));
    check({id, ".warn"}, 32'(w), 32'(WARN_ON && run_exp && (m.limit - m.count <= MARG)));
  endtask

  task automatic compare_all();
    compare_one("a", ma, count_a, running_a, expired_a, pulse_a, warn_a);
    compare_one("b", mb, count_b, running_b, expired_b, pulse_b, warn_b);
  endtask

  task automatic cyc(input bit st, input bit ps, input bit cl, input bit tk, input bit ar, input int cfg);
    start = st; pause = ps; clear = cl; tick = tk; auto_reload = ar; cfg_limit = cfg[W-1:0];
    @(posedge clock);
    #1;
    ma = model_step(ma, 1'b1, st, ps, cl, tk, ar, cfg);
    mb = model_step(mb, 1'b0, st, ps, cl, tk, ar, cfg);
    compare_all();
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0;
    auto_reload = 1'b0; cfg_limit = '0;
    ma = model_reset(); mb = model_reset();
    #3;
    compare_all();
    #5 reset = 1'b0;

    // one-shot, limit 5, tick held high past expiry
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      pulses += int'(pulse_a);
    end
    check("tp1.count", 32'(count_a), 32'd5);
    check("tp1.pulses", 32'(pulses), 32'd1);
    check("tp1.running", 32'(running_a), 32'd0);

    // auto-reload, limit 3, nine ticks
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      pulses += int'(pulse_a);
    end
    check("tp2.pulses", 32'(pulses), 32'd3);
    check("tp2.running", 32'(running_a), 32'd1);
    check("tp2.count", 32'(count_a), 32'd0);

    // pause holds the count
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("tp3.hold", 32'(count_a), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("tp3.count", 32'(count_a), 32'd10);
    check("tp3.expired", 32'(expired_a), 32'd1);

    // zero limit: default substitution on a, immediate expiry on b
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("tp4.b_pulse", 32'(pulse_b), 32'd1);
    check("tp4.b_count", 32'(count_b), 32'd0);
    for (int i = 0; i < DEF - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("tp4.a_not_yet", 32'(expired_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("tp4.a_expired", 32'(expired_a), 32'd1);

    // start beats a tick that would have expired the timer
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("tp5.pre_count", 32'(count_a), 32'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    check("tp5.count", 32'(count_a), 32'd0);
    check("tp5.expired", 32'(expired_a), 32'd0);
    check("tp5.pulse", 32'(pulse_a), 32'd0);

    // clear beats start
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    check("tp6.running", 32'(running_a), 32'd0);

    // warn window with limit 6
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // asynchronous reset between edges
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    start = 1'b0; tick = 1'b0;
    #1 reset = 1'b1;
    #1;
    ma = model_reset(); mb = model_reset();
    check("tp7.count", 32'(count_a), 32'd0);
    check("tp7.running", 32'(running_a), 32'd0);
    compare_all();
    reset = 1'b0;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
